// File: rtl/qpl_block_responder.sv
// qpl_block_responder: round-robin write/read arbitration of CHANS requesters onto one
// simple-dual-port RAM. Optional macro QPL_RESP_WR_BYPASS_EN forwards same-cycle write data to a colliding read.
module qpl_block_responder #(
    parameter int CHANS   = 8,
    parameter int BLOCK_D = 16,
    parameter int WORD_W  = 4,
    parameter int DATA_W  = 32,
    parameter int OREG_EN = 1,
    localparam int BLOCK_W = $clog2(BLOCK_D),
    localparam int PADDR_W = BLOCK_W + WORD_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [CHANS-1:0]         i_base_we,
    input  logic [CHANS*PADDR_W-1:0] i_base_addr,
    input  logic [CHANS*DATA_W-1:0]  i_base_wdata,
    output logic [CHANS-1:0]         o_base_rdy,
    input  logic [CHANS-1:0]         i_aux_we,
    input  logic [CHANS*PADDR_W-1:0] i_aux_addr,
    output logic [CHANS-1:0]         o_aux_rdy,
    output logic [CHANS-1:0]         o_rd_vld,
    output logic [DATA_W-1:0]        o_rd_data
);
    localparam int CH_W  = (CHANS > 1) ? $clog2(CHANS) : 1;
    localparam int DEPTH = 1 << PADDR_W;

    function automatic void rr_pick(input logic [CHANS-1:0] req, input logic [CH_W-1:0] ptr,
                                    output logic found, output logic [CH_W-1:0] idx);
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < CHANS; k++) begin
            int c;
            c = (int'(ptr) + k) % CHANS;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = CH_W'(c);
            end
        end
    endfunction

    function automatic logic [CHANS-1:0] onehot(input logic [CH_W-1:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

    logic [CH_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic               wr_found, rd_found, wr_go, rd_go;
    logic [CH_W-1:0]    wr_idx, rd_idx;
    logic [PADDR_W-1:0] wr_addr, rd_addr;
    logic [DATA_W-1:0]  wr_data;

    always_comb begin
        wr_found = 1'b0;
        wr_idx   = '0;
        rd_found = 1'b0;
        rd_idx   = '0;
        rr_pick(i_base_we, wr_ptr_q, wr_found, wr_idx);
        rr_pick(i_aux_we, rd_ptr_q, rd_found, rd_idx);
        // Grants are suppressed for the whole time reset is asserted.
        wr_go      = wr_found && !i_rst;
        rd_go      = rd_found && !i_rst;
        o_base_rdy = wr_go ? onehot(wr_idx) : '0;
        o_aux_rdy  = rd_go ? onehot(rd_idx) : '0;
        wr_addr    = i_base_addr[wr_idx*PADDR_W +: PADDR_W];
        wr_data    = i_base_wdata[wr_idx*DATA_W +: DATA_W];
        rd_addr    = i_aux_addr[rd_idx*PADDR_W +: PADDR_W];
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        if (wr_go) wr_ptr_d = (wr_idx == CH_W'(CHANS-1)) ? '0 : wr_idx + 1'b1;
        if (rd_go) rd_ptr_d = (rd_idx == CH_W'(CHANS-1)) ? '0 : rd_idx + 1'b1;
    end

    logic              rd1_vld_q;
    logic [CH_W-1:0]   rd1_ch_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd1_vld_q <= 1'b0;
            rd1_ch_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd1_vld_q <= rd_go;
            if (rd_go) rd1_ch_q <= rd_idx;
        end
    end

    // Storage has no reset so it maps onto block RAM; the read port is read-first.
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_rd_q;
    logic [DATA_W-1:0] ram_dout;

    always_ff @(posedge i_clk) begin
        if (wr_go) mem[wr_addr] <= wr_data;
        if (rd_go) ram_rd_q <= mem[rd_addr];
    end

`ifdef QPL_RESP_WR_BYPASS_EN
    logic              byp_q;
    logic [DATA_W-1:0] byp_data_q;

    always_ff @(posedge i_clk) begin
        byp_q      <= wr_go && rd_go && (wr_addr == rd_addr);
        byp_data_q <= wr_data;
    end

    assign ram_dout = byp_q ? byp_data_q : ram_rd_q;
`else
    assign ram_dout = ram_rd_q;
`endif

    generate
        if (OREG_EN != 0) begin : g_oreg
            logic              rd2_vld_q;
            logic [CH_W-1:0]   rd2_ch_q;
            logic [DATA_W-1:0] rd_data_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    rd2_vld_q <= 1'b0;
                    rd2_ch_q  <= '0;
                    rd_data_q <= '0;
                end else begin
                    rd2_vld_q <= rd1_vld_q;
                    rd2_ch_q  <= rd1_ch_q;
                    if (rd1_vld_q) rd_data_q <= ram_dout;
                end
            end

            assign o_rd_vld  = rd2_vld_q ? onehot(rd2_ch_q) : '0;
            assign o_rd_data = rd_data_q;
        end else begin : g_noreg
            // Holding register keeps the data bus stable between responses.
            logic [DATA_W-1:0] last_q;

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) last_q <= '0;
                else if (rd1_vld_q) last_q <= ram_dout;
            end

            assign o_rd_vld  = rd1_vld_q ? onehot(rd1_ch_q) : '0;
            assign o_rd_data = rd1_vld_q ? ram_dout : last_q;
        end
    endgenerate

`ifndef SYNTHESIS
    generate
        for (genvar gi = 0; gi < CHANS; gi++) begin : g_req_stable
            a_base_hold: assert property (@(posedge i_clk) disable iff (i_rst)
                (i_base_we[gi] && !o_base_rdy[gi]) |=>
                (i_base_we[gi] && $stable(i_base_addr[gi*PADDR_W +: PADDR_W])
                               && $stable(i_base_wdata[gi*DATA_W +: DATA_W])));
            a_aux_hold: assert property (@(posedge i_clk) disable iff (i_rst)
                (i_aux_we[gi] && !o_aux_rdy[gi]) |=>
                (i_aux_we[gi] && $stable(i_aux_addr[gi*PADDR_W +: PADDR_W])));
        end
    endgenerate
`endif
endmodule

// File: tb/tb_qpl_block_responder.sv
// Directed bench for qpl_block_responder: one OREG_EN=1 instance and one OREG_EN=0 instance.
module tb_qpl_block_responder;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   base_we = '0, aux_we = '0, base_rdy, aux_rdy, rd_vld;
    logic [63:0]  base_addr = '0, aux_addr = '0;
    logic [255:0] base_wdata = '0;
    logic [31:0]  rd_data;
    logic [7:0]   base_we0 = '0, aux_we0 = '0, base_rdy0, aux_rdy0, rd_vld0;
    logic [63:0]  base_addr0 = '0, aux_addr0 = '0;
    logic [255:0] base_wdata0 = '0;
    logic [31:0]  rd_data0;
    int checks = 0;
    int failures = 0;

`ifdef QPL_RESP_WR_BYPASS_EN
    localparam logic [31:0] BYP_EXP = 32'h11111111;
`else
    localparam logic [31:0] BYP_EXP = 32'h22222222;
`endif

    always #5 clk = ~clk;

    qpl_block_responder #(.OREG_EN(1)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_base_we(base_we), .i_base_addr(base_addr), .i_base_wdata(base_wdata), .o_base_rdy(base_rdy),
        .i_aux_we(aux_we), .i_aux_addr(aux_addr), .o_aux_rdy(aux_rdy),
        .o_rd_vld(rd_vld), .o_rd_data(rd_data)
    );

    qpl_block_responder #(.OREG_EN(0)) dut0 (
        .i_clk(clk), .i_rst(rst),
        .i_base_we(base_we0), .i_base_addr(base_addr0), .i_base_wdata(base_wdata0), .o_base_rdy(base_rdy0),
        .i_aux_we(aux_we0), .i_aux_addr(aux_addr0), .o_aux_rdy(aux_rdy0),
        .o_rd_vld(rd_vld0), .o_rd_data(rd_data0)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int c, input logic [7:0] a, input logic [31:0] d);
        base_addr[c*8 +: 8]   = a;
        base_wdata[c*32 +: 32] = d;
    endtask

    task automatic set_rd(input int c, input logic [7:0] a);
        aux_addr[c*8 +: 8] = a;
    endtask

    task automatic do_reset;
        base_we = '0; aux_we = '0; base_we0 = '0; aux_we0 = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        base_we = 8'hFF; aux_we = 8'hFF; base_we0 = 8'hFF; aux_we0 = 8'hFF;
        tick();
        @(negedge clk);
        checks++; if (base_rdy !== 8'h00) begin failures++; $display("FAIL reset_base_rdy: got %h want 00", base_rdy); end
        checks++; if (aux_rdy !== 8'h00) begin failures++; $display("FAIL reset_aux_rdy: got %h want 00", aux_rdy); end
        checks++; if (aux_rdy0 !== 8'h00) begin failures++; $display("FAIL reset_aux_rdy0: got %h want 00", aux_rdy0); end
        checks++; if (rd_vld !== 8'h00) begin failures++; $display("FAIL reset_rd_vld: got %h want 00", rd_vld); end
        checks++; if (rd_data !== 32'h0) begin failures++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        checks++; if (rd_vld0 !== 8'h00) begin failures++; $display("FAIL reset_rd_vld0: got %h want 00", rd_vld0); end
        checks++; if (rd_data0 !== 32'h0) begin failures++; $display("FAIL reset_rd_data0: got %h want 0", rd_data0); end
        do_reset();
        @(negedge clk);
        checks++; if (base_rdy !== 8'h00) begin failures++; $display("FAIL idle_base_rdy: got %h want 00", base_rdy); end
    endtask

    task automatic test_single_rw;
        set_wr(2, 8'h35, 32'hDEADBEEF);
        base_we = 8'h04;
        @(negedge clk);
        checks++; if (base_rdy !== 8'h04) begin failures++; $display("FAIL single_wr_gnt: got %h want 04", base_rdy); end
        tick();
        base_we = '0;
        set_rd(5, 8'h35);
        aux_we = 8'h20;
        @(negedge clk);
        checks++; if (aux_rdy !== 8'h20) begin failures++; $display("FAIL single_rd_gnt: got %h want 20", aux_rdy); end
        tick();
        aux_we = '0;
        @(negedge clk);
        checks++; if (rd_vld !== 8'h00) begin failures++; $display("FAIL single_t1_vld: got %h want 00", rd_vld); end
        tick();
        @(negedge clk);
        checks++; if (rd_vld !== 8'h20) begin failures++; $display("FAIL single_t2_vld: got %h want 20", rd_vld); end
        checks++; if (rd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_t2_data: got %h want deadbeef", rd_data); end
        tick();
        @(negedge clk);
        checks++; if (rd_vld !== 8'h00) begin failures++; $display("FAIL single_t3_vld: got %h want 00", rd_vld); end
        checks++; if (rd_data !== 32'hDEADBEEF) begin failures++; $display("FAIL single_hold_data: got %h want deadbeef", rd_data); end
    endtask

    task automatic test_write_rr;
        logic [7:0] exp;
        do_reset();
        for (int c = 0; c < 8; c++) set_wr(c, 8'h80 + 8'(c), 32'(c));
        base_we = 8'hFF;
        // 18 grants: 0..7,0,1 with all held, then each channel drops once granted.
        for (int i = 0; i < 18; i++) begin
            exp = 8'h01 << (i % 8);
            @(negedge clk);
            checks++; if (base_rdy !== exp) begin failures++; $display("FAIL wr_rr_gnt[%0d]: got %h want %h", i, base_rdy, exp); end
            tick();
            if (i >= 10) base_we[i % 8] = 1'b0;
        end
        @(negedge clk);
        checks++; if (base_rdy !== 8'h00) begin failures++; $display("FAIL wr_rr_drained: got %h want 00", base_rdy); end
    endtask

    task automatic test_read_alt;
        logic [7:0] gnt [4];
        logic [31:0] dat [4];
        logic [7:0] exp;
        gnt[0] = 8'h08; gnt[1] = 8'h40; gnt[2] = 8'h08; gnt[3] = 8'h40;
        dat[0] = 32'h33333333; dat[1] = 32'h66666666; dat[2] = 32'h33333333; dat[3] = 32'h66666666;
        do_reset();
        set_wr(0, 8'h03, 32'h33333333);
        base_we = 8'h01;
        tick();
        set_wr(0, 8'h06, 32'h66666666);
        tick();
        base_we = '0;
        set_rd(3, 8'h03);
        set_rd(6, 8'h06);
        aux_we = 8'h48;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            exp = (k < 4) ? gnt[k] : 8'h00;
            checks++; if (aux_rdy !== exp) begin failures++; $display("FAIL alt_gnt[%0d]: got %h want %h", k, aux_rdy, exp); end
            exp = (k >= 2) ? gnt[k-2] : 8'h00;
            checks++; if (rd_vld !== exp) begin failures++; $display("FAIL alt_vld[%0d]: got %h want %h", k, rd_vld, exp); end
            if (k >= 2) begin
                checks++; if (rd_data !== dat[k-2]) begin failures++; $display("FAIL alt_data[%0d]: got %h want %h", k, rd_data, dat[k-2]); end
            end
            tick();
            if (k == 2) aux_we[3] = 1'b0;
            if (k == 3) aux_we[6] = 1'b0;
        end
    endtask

    task automatic test_same_addr;
        do_reset();
        set_wr(0, 8'h10, 32'h22222222);
        base_we = 8'h01;
        tick();
        set_wr(1, 8'h10, 32'h11111111);
        base_we = 8'h02;
        set_rd(4, 8'h10);
        aux_we = 8'h10;
        @(negedge clk);
        checks++; if (base_rdy !== 8'h02) begin failures++; $display("FAIL coll_wr_gnt: got %h want 02", base_rdy); end
        checks++; if (aux_rdy !== 8'h10) begin failures++; $display("FAIL coll_rd_gnt: got %h want 10", aux_rdy); end
        tick();
        base_we = '0;
        aux_we = '0;
        tick();
        @(negedge clk);
        checks++; if (rd_vld !== 8'h10) begin failures++; $display("FAIL coll_vld: got %h want 10", rd_vld); end
        checks++; if (rd_data !== BYP_EXP) begin failures++; $display("FAIL coll_data: got %h want %h", rd_data, BYP_EXP); end
        tick();
        aux_we = 8'h10;
        tick();
        aux_we = '0;
        tick();
        @(negedge clk);
        checks++; if (rd_data !== 32'h11111111) begin failures++; $display("FAIL coll_after: got %h want 11111111", rd_data); end
    endtask

    task automatic test_reset_mid_read;
        logic [7:0] exp;
        do_reset();
        set_wr(0, 8'h77, 32'h77777777);
        base_we = 8'h01;
        tick();
        base_we = '0;
        set_rd(7, 8'h77);
        aux_we = 8'h80;
        @(negedge clk);
        checks++; if (aux_rdy !== 8'h80) begin failures++; $display("FAIL mid_gnt7: got %h want 80", aux_rdy); end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 8; c++) set_rd(c, 8'(c));
        aux_we = 8'hFF;
        @(negedge clk);
        checks++; if (aux_rdy !== 8'h00) begin failures++; $display("FAIL mid_rst_gnt: got %h want 00", aux_rdy); end
        checks++; if (rd_vld !== 8'h00) begin failures++; $display("FAIL mid_rst_vld: got %h want 00", rd_vld); end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            exp = (i < 8) ? (8'h01 << i) : 8'h00;
            checks++; if (aux_rdy !== exp) begin failures++; $display("FAIL mid_gnt[%0d]: got %h want %h", i, aux_rdy, exp); end
            exp = (i >= 2) ? (8'h01 << (i - 2)) : 8'h00;
            checks++; if (rd_vld !== exp) begin failures++; $display("FAIL mid_vld[%0d]: got %h want %h", i, rd_vld, exp); end
            tick();
            if (i < 8) aux_we[i] = 1'b0;
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] exp_d;
        do_reset();
        base_we0 = 8'h01;
        for (int i = 0; i < 4; i++) begin
            base_addr0[7:0]  = 8'(i);
            base_wdata0[31:0] = 32'hA0 + 32'(i);
            @(negedge clk);
            checks++; if (base_rdy0 !== 8'h01) begin failures++; $display("FAIL b2b_wr_gnt[%0d]: got %h want 01", i, base_rdy0); end
            tick();
        end
        base_we0 = '0;
        aux_addr0[7:0] = 8'h00;
        aux_we0 = 8'h01;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i < 4) begin
                checks++; if (aux_rdy0 !== 8'h01) begin failures++; $display("FAIL b2b_rd_gnt[%0d]: got %h want 01", i, aux_rdy0); end
            end
            if (i == 0) begin
                checks++; if (rd_vld0 !== 8'h00) begin failures++; $display("FAIL b2b_vld[0]: got %h want 00", rd_vld0); end
            end else begin
                exp_d = 32'hA0 + 32'(i - 1);
                checks++; if (rd_vld0 !== 8'h01) begin failures++; $display("FAIL b2b_vld[%0d]: got %h want 01", i, rd_vld0); end
                checks++; if (rd_data0 !== exp_d) begin failures++; $display("FAIL b2b_data[%0d]: got %h want %h", i, rd_data0, exp_d); end
            end
            tick();
            if (i < 3) aux_addr0[7:0] = 8'(i + 1);
            if (i == 3) aux_we0 = '0;
        end
        @(negedge clk);
        checks++; if (rd_vld0 !== 8'h00) begin failures++; $display("FAIL b2b_idle_vld: got %h want 00", rd_vld0); end
        checks++; if (rd_data0 !== 32'hA3) begin failures++; $display("FAIL b2b_hold: got %h want 000000a3", rd_data0); end
    endtask

    initial begin
        test_reset();
        test_single_rw();
        test_write_rr();
        test_read_alt();
        test_same_addr();
        test_reset_mid_read();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
